acc_serializer: RTL and testbench

// - Sits between the NU_COUNT parallel MAC accumulators and the activation LUT.
// - Captures all accumulators in one cycle and requantizes each to signed Q_SIZE
//   (round half-up, saturate).
// - Presents the lanes one per cycle, lane 0 first, as the activation LUT address stream.
// - A holding bank lets the next capture (ACCMOV) overlap the tail of the current shift-out.

---
 rtl/acc_serializer_pkg.sv | 18 +
 rtl/acc_serializer_q_requant.sv | 9 +
 rtl/acc_serializer.sv | 75 +++++++
 tb/tb_acc_serializer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/acc_serializer_pkg.sv
// acc_serializer_pkg: shared widths, types and the accumulator-to-Q requantizer.
package acc_serializer_pkg;
  localparam int ACC_SIZE = 32;
  localparam int Q_SIZE = 16;
  localparam int FRAC_SHIFT = 8;
  typedef logic signed [ACC_SIZE-1:0] acc_t;
  typedef logic signed [Q_SIZE-1:0] q_t;
  typedef enum logic [1:0] {IDLE, SHIFT, SHIFT_PEND} state_t;
  localparam logic signed [ACC_SIZE:0] RND = ((ACC_SIZE+1)'(1) << FRAC_SHIFT) >> 1;
  localparam logic signed [ACC_SIZE:0] Q_MAX = (ACC_SIZE+1)'((64'sd1 <<< (Q_SIZE-1)) - 64'sd1);
  localparam logic signed [ACC_SIZE:0] Q_MIN = ~Q_MAX;
  // One extra bit keeps the rounding add from wrapping at the positive extreme.
  function automatic q_t acc_to_q(acc_t acc);
    logic signed [ACC_SIZE:0] r;
    r = ($signed({acc[ACC_SIZE-1], acc}) + RND) >>> FRAC_SHIFT;
    return r > Q_MAX ? q_t'(Q_MAX) : r < Q_MIN ? q_t'(Q_MIN) : q_t'(r);
  endfunction
endpackage

// File: rtl/acc_serializer_q_requant.sv
// q_requant: combinational round-half-up and saturate of one accumulator lane.
module q_requant
  import acc_serializer_pkg::*;
(
  input  acc_t acc,
  output q_t   q
);
  assign q = acc_to_q(acc);
endmodule

// File: rtl/acc_serializer.sv
// acc_serializer: captures requantized accumulator lanes and streams them one per cycle,
// with a holding bank so the next capture can overlap the current shift-out.
module acc_serializer
  import acc_serializer_pkg::*;
#(
  parameter int NU_COUNT = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  update,
  input  logic                                  shift,
  input  logic [NU_COUNT-1:0][ACC_SIZE-1:0]     acc_in,
  input  logic                                  clear_overrun,
  output q_t                                    q_out,
  output logic                                  q_valid,
  output logic                                  pending,
  output logic                                  busy,
  output logic [$clog2(NU_COUNT+1)-1:0]         remaining,
  output logic                                  overrun
);
  localparam int RW = $clog2(NU_COUNT+1);
  state_t state, state_nx;
  logic [RW-1:0] rem_nx;
  logic ov_nx, last, xfer, load, hold, pop;
  q_t conv [NU_COUNT];
  q_t sbank [NU_COUNT];
  q_t sbank_nx [NU_COUNT];
  q_t hbank [NU_COUNT];
  q_t hbank_nx [NU_COUNT];
  q_t shifted [NU_COUNT];
  for (genvar i = 0; i < NU_COUNT; i++) begin : g_rq
    q_requant u_rq (.acc(acc_t'(acc_in[i])), .q(conv[i]));
  end
  // A frame enters the shift bank when it empties this cycle (or already is empty);
  // otherwise it parks in the holding bank, replacing anything already parked.
  always_comb begin
    last = remaining == RW'(1) && shift;
    xfer = state == SHIFT_PEND && last;
    load = update && (state == IDLE || (state == SHIFT && last));
    hold = update && !load;
    pop = shift && state != IDLE;
    state_nx = hold ? SHIFT_PEND : (load || xfer) ? SHIFT : last ? IDLE : state;
    rem_nx = (load || xfer) ? RW'(NU_COUNT) : pop ? remaining - RW'(1) : remaining;
    ov_nx = (update && state == SHIFT_PEND && !xfer) || (overrun && !clear_overrun);
    for (int i = 0; i < NU_COUNT - 1; i++) shifted[i] = sbank[i+1];
    shifted[NU_COUNT-1] = '0;
    for (int i = 0; i < NU_COUNT; i++) begin
      sbank_nx[i] = load ? conv[i] : xfer ? hbank[i] : pop ? shifted[i] : sbank[i];
      hbank_nx[i] = hold ? conv[i] : hbank[i];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      remaining <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < NU_COUNT; i++) begin
        sbank[i] <= '0;
        hbank[i] <= '0;
      end
    end else begin
      state <= state_nx;
      remaining <= rem_nx;
      overrun <= ov_nx;
      for (int i = 0; i < NU_COUNT; i++) begin
        sbank[i] <= sbank_nx[i];
        hbank[i] <= hbank_nx[i];
      end
    end
  end
  assign q_out = sbank[0];
  assign q_valid = state != IDLE;
  assign pending = state == SHIFT_PEND;
  assign busy = q_valid || pending;
endmodule

// File: tb/tb_acc_serializer.sv
// tb_acc_serializer: directed and random stimulus against a queue-based frame model.
module tb_acc_serializer;
  import acc_serializer_pkg::*;
  localparam int NU = 4;
  logic clk = 1'b0, reset = 1'b1, update = 1'b0, shift = 1'b0, clear_overrun = 1'b0;
  logic [NU-1:0][ACC_SIZE-1:0] acc_in = '0;
  q_t q_out;
  logic q_valid, pending, busy, overrun;
  logic [2:0] remaining;
  int compared = 0, mismatched = 0;
  q_t sq[$], hq[$];
  bit hv = 0, ov = 0;
  q_t rnd_exp [NU] = '{16'sd2, -16'sd1, 16'sd0, 16'sd1};
  q_t sat_exp [NU] = '{16'sh7FFF, 16'sh8000, 16'sh7FFF, 16'sh8000};

  acc_serializer #(.NU_COUNT(NU)) dut (
    .clk(clk), .reset(reset), .update(update), .shift(shift), .acc_in(acc_in),
    .clear_overrun(clear_overrun), .q_out(q_out), .q_valid(q_valid), .pending(pending),
    .busy(busy), .remaining(remaining), .overrun(overrun)
  );
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level model: a queue of lanes still to emit and one optional parked frame.
  task automatic model(bit u, bit s, bit c);
    bit xf;
    q_t conv[$];
    xf = sq.size() == 0 || (sq.size() == 1 && s);
    if (c) ov = 0;
    if (s && sq.size() > 0) void'(sq.pop_front());
    if (xf && hv) begin
      sq = hq;
      hv = 0;
    end
    if (u) begin
      for (int i = 0; i < NU; i++) conv.push_back(acc_to_q(acc_in[i]));
      if (xf && sq.size() == 0) sq = conv;
      else begin
        if (hv) ov = 1;
        hq = conv;
        hv = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("q_valid", q_valid, sq.size() != 0);
    chk("remaining", remaining, sq.size());
    chk("pending", pending, hv);
    chk("busy", busy, sq.size() != 0 || hv);
    chk("overrun", overrun, ov);
    if (sq.size() != 0) chk("q_out", q_out, sq[0]);
  endtask

  task automatic step(bit u, bit s, bit c);
    update = u;
    shift = s;
    clear_overrun = c;
    @(posedge clk);
    model(u, s, c);
    #1;
    check_all();
    update = 0;
    shift = 0;
    clear_overrun = 0;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < NU; i++)
      acc_in[i] = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
  endtask

  initial begin
    #1;
    chk("reset_valid", q_valid, 0);
    chk("reset_remaining", remaining, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_pending", pending, 0);
    @(posedge clk);
    #1 reset = 0;
    // rounding
    acc_in = {32'h80, 32'h7F, -32'sh180, 32'h180};
    step(1, 0, 0);
    for (int k = 0; k < NU; k++) begin
      chk("round_const", q_out, rnd_exp[k]);
      step(0, 1, 0);
    end
    chk("round_end_valid", q_valid, 0);
    // saturation
    acc_in = {32'hFF80_0000, 32'h007F_FF80, 32'h8000_0000, 32'h7FFF_FFFF};
    step(1, 0, 0);
    for (int k = 0; k < NU; k++) begin
      chk("sat_const", q_out, sat_exp[k]);
      step(0, 1, 0);
    end
    // back-to-back
    rand_frame();
    step(1, 0, 0);
    while (sq.size() != 2) step(0, 1, 0);
    rand_frame();
    step(1, 1, 0);
    for (int k = 0; k < 7; k++) step(0, 1, 0);
    chk("b2b_overrun", overrun, 0);
    // overrun: A, then B and C while pending
    for (int k = 0; k < 3; k++) begin
      rand_frame();
      step(1, 0, 0);
    end
    chk("ovr_set", overrun, 1);
    for (int k = 0; k < 2 * NU; k++) step(0, 1, 0);
    step(0, 0, 1);
    chk("ovr_clear", overrun, 0);
    // empty shift and update+shift in idle
    step(0, 1, 0);
    step(0, 1, 0);
    rand_frame();
    step(1, 1, 0);
    chk("idle_upd_shift_rem", remaining, NU);
    // reset mid-frame at remaining=2 with pending
    for (int k = 0; k < NU; k++) step(0, 1, 0);
    rand_frame();
    step(1, 0, 0);
    rand_frame();
    step(1, 1, 0);
    step(0, 1, 0);
    chk("pre_reset_pending", pending, 1);
    #2 reset = 1;
    #1;
    sq.delete();
    hq.delete();
    hv = 0;
    ov = 0;
    check_all();
    @(posedge clk);
    #1 reset = 0;
    step(0, 1, 0);
    step(0, 0, 0);
    // random traffic
    for (int k = 0; k < 400; k++) begin
      rand_frame();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
